// File: rtl/lcd_pkg.sv
// Shared constants, state encodings and helpers for the HD44780-class word display.
package lcd_pkg;

    localparam logic [7:0] FUNC_SET_8B2L     = 8'h38;
    localparam logic [7:0] DISP_ON_CUR_BLINK = 8'h0F;
    localparam logic [7:0] ENTRY_INC         = 8'h06;
    localparam logic [7:0] CLEAR             = 8'h01;
    localparam logic [7:0] HOME              = 8'h02;
    localparam logic [7:0] SET_DDRAM         = 8'h80;
    localparam logic [7:0] ASCII_0           = 8'h30;
    localparam logic [7:0] ASCII_A           = 8'h41;

    typedef enum logic [2:0] {StInit, StIdle, StAddr, StChar, StDone} state_e;
    typedef enum logic [2:0] {PhIdle, PhSetup, PhStrobe, PhHold, PhWait} phase_e;

    function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return ASCII_0 + {4'h0, nib};
        end
        return ASCII_A + {4'h0, nib} - 8'd10;
    endfunction

    function automatic logic [7:0] init_byte(input logic [1:0] idx);
        case (idx)
            2'd0:    return FUNC_SET_8B2L;
            2'd1:    return DISP_ON_CUR_BLINK;
            2'd2:    return ENTRY_INC;
            default: return CLEAR;
        endcase
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lcd_word_display_if.sv
// Word-input handshake between the status source and the LCD word display.
interface lcd_word_display_if #(
    parameter int unsigned DATA_W = 10
) ();
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_hex;
    logic              in_ready;

    modport master (output in_valid, output in_data, output in_hex, input in_ready);
    modport slave  (input in_valid, input in_data, input in_hex, output in_ready);
endinterface

// File: rtl/lcd_write_phy.sv
// Single timed LCD byte write: SETUP, E strobe, HOLD, then command wait.
module lcd_write_phy
    import lcd_pkg::*;
#(
    parameter int unsigned SETUP_CYC = 2,
    parameter int unsigned EN_CYC    = 12,
    parameter int unsigned HOLD_CYC  = 2,
    parameter int unsigned CMD_WAIT  = 2000,
    parameter int unsigned CLR_WAIT  = 80000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_i,
    input  logic [7:0] byte_i,
    input  logic       rs_i,
    input  logic       long_wait_i,
    output logic       ready_o,
    output logic       ack_o,
    output logic [7:0] lcd_data_o,
    output logic       lcd_rs_o,
    output logic       lcd_en_o
);

    localparam int unsigned MAX_CYC = max_u(max_u(SETUP_CYC, EN_CYC),
                                            max_u(HOLD_CYC, max_u(CMD_WAIT, CLR_WAIT)));
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] EN_LD    = CNT_W'(EN_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] CMD_LD   = CNT_W'(CMD_WAIT - 1);
    localparam logic [CNT_W-1:0] CLR_LD   = CNT_W'(CLR_WAIT - 1);

    phase_e           phase_q, phase_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       data_q, data_d;
    logic             rs_q, rs_d;
    logic             long_q, long_d;
    logic             en_q, en_d;

    // Accepting on the last wait cycle keeps back-to-back bytes gap-free.
    assign ack_o   = (phase_q == PhWait) && (cnt_q == '0);
    assign ready_o = (phase_q == PhIdle) || ack_o;

    always_comb begin
        phase_d = phase_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        rs_d    = rs_q;
        long_d  = long_q;
        case (phase_q)
            PhSetup: begin
                if (cnt_q == '0) begin
                    phase_d = PhStrobe;
                    cnt_d   = EN_LD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            PhStrobe: begin
                if (cnt_q == '0) begin
                    phase_d = PhHold;
                    cnt_d   = HOLD_LD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            PhHold: begin
                if (cnt_q == '0) begin
                    phase_d = PhWait;
                    cnt_d   = long_q ? CLR_LD : CMD_LD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            PhWait: begin
                if (cnt_q == '0) begin
                    phase_d = PhIdle;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: ;
        endcase
        if (ready_o && req_i) begin
            phase_d = PhSetup;
            cnt_d   = SETUP_LD;
            data_d  = byte_i;
            rs_d    = rs_i;
            long_d  = long_wait_i;
        end
        en_d = (phase_d == PhStrobe);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= PhIdle;
            cnt_q   <= '0;
            data_q  <= 8'h00;
            rs_q    <= 1'b0;
            long_q  <= 1'b0;
            en_q    <= 1'b0;
        end else begin
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            rs_q    <= rs_d;
            long_q  <= long_d;
            en_q    <= en_d;
        end
    end

    assign lcd_data_o = data_q;
    assign lcd_rs_o   = rs_q;
    assign lcd_en_o   = en_q;

endmodule

// File: rtl/lcd_word_display.sv
// Character-LCD word printer: power-on init, then prints each accepted word at
// DDRAM address 0 as binary or uppercase hex digits.
module lcd_word_display
    import lcd_pkg::*;
#(
    parameter int unsigned DATA_W    = 10,
    parameter int unsigned SETUP_CYC = 2,
    parameter int unsigned EN_CYC    = 12,
    parameter int unsigned HOLD_CYC  = 2,
    parameter int unsigned CMD_WAIT  = 2000,
    parameter int unsigned CLR_WAIT  = 80000
) (
    input  logic                 clk,
    input  logic                 rst,
    lcd_word_display_if.slave    in_if,
    output logic                 busy,
    output logic                 done,
    output logic [7:0]           lcd_data,
    output logic                 lcd_rs,
    output logic                 lcd_rw,
    output logic                 lcd_en
);

    localparam int unsigned NDIG  = (DATA_W + 3) / 4;
    localparam int unsigned HEX_W = 4 * NDIG;
    localparam int unsigned IDX_W = $clog2(DATA_W + 1);

    localparam logic [IDX_W-1:0] LAST_BIN = IDX_W'(DATA_W - 1);
    localparam logic [IDX_W-1:0] LAST_HEX = IDX_W'(NDIG - 1);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [1:0]        init_idx_q, init_idx_d;
    logic [DATA_W-1:0] word_q, word_d;
    logic              hex_q, hex_d;

    logic              phy_req, phy_rs, phy_long, phy_ready, phy_ack;
    logic [7:0]        phy_byte, char_byte;
    logic [HEX_W-1:0]  word_ext, word_sh;
    logic              bin_bit;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        init_idx_d = init_idx_q;
        word_d     = word_q;
        hex_d      = hex_q;
        case (state_q)
            StInit: begin
                if (phy_ack) begin
                    if (init_idx_q == 2'd3) begin
                        state_d    = StIdle;
                        init_idx_d = 2'd0;
                    end else begin
                        init_idx_d = init_idx_q + 2'd1;
                    end
                end
            end
            StIdle: begin
                if (in_if.in_valid) begin
                    word_d  = in_if.in_data;
                    hex_d   = in_if.in_hex;
                    state_d = StAddr;
                end
            end
            StAddr: begin
                if (phy_ack) begin
                    state_d = StChar;
                    idx_d   = '0;
                end
            end
            StChar: begin
                if (phy_ack) begin
                    if (idx_q == (hex_q ? LAST_HEX : LAST_BIN)) begin
                        state_d = StDone;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StInit;
        endcase
    end

    // Digits are taken MSB first; idx_d selects the digit about to be issued.
    always_comb begin
        word_ext                = '0;
        word_ext[DATA_W-1:0]    = word_q;
        word_sh                 = word_ext >> (4 * (NDIG - 1 - 32'(idx_d)));
        bin_bit                 = 1'(word_q >> (DATA_W - 1 - 32'(idx_d)));
        char_byte               = hex_q ? nibble_to_ascii(4'(word_sh))
                                        : ASCII_0 + {7'd0, bin_bit};
    end

    // Requests follow the next state so a new byte starts on the previous ack.
    always_comb begin
        phy_req  = 1'b0;
        phy_byte = 8'h00;
        phy_rs   = 1'b0;
        case (state_d)
            StInit: begin
                phy_req  = phy_ready;
                phy_byte = init_byte(init_idx_d);
            end
            StAddr: begin
                phy_req  = phy_ready;
                phy_byte = SET_DDRAM;
            end
            StChar: begin
                phy_req  = phy_ready;
                phy_rs   = 1'b1;
                phy_byte = char_byte;
            end
            default: ;
        endcase
        phy_long = !phy_rs && ((phy_byte == CLEAR) || (phy_byte == HOME));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StInit;
            idx_q      <= '0;
            init_idx_q <= 2'd0;
            word_q     <= '0;
            hex_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            init_idx_q <= init_idx_d;
            word_q     <= word_d;
            hex_q      <= hex_d;
        end
    end

    lcd_write_phy #(
        .SETUP_CYC (SETUP_CYC),
        .EN_CYC    (EN_CYC),
        .HOLD_CYC  (HOLD_CYC),
        .CMD_WAIT  (CMD_WAIT),
        .CLR_WAIT  (CLR_WAIT)
    ) u_phy (
        .clk         (clk),
        .rst         (rst),
        .req_i       (phy_req),
        .byte_i      (phy_byte),
        .rs_i        (phy_rs),
        .long_wait_i (phy_long),
        .ready_o     (phy_ready),
        .ack_o       (phy_ack),
        .lcd_data_o  (lcd_data),
        .lcd_rs_o    (lcd_rs),
        .lcd_en_o    (lcd_en)
    );

    assign in_if.in_ready = (state_q == StIdle);
    assign busy           = (state_q != StIdle);
    assign done           = (state_q == StDone);
    assign lcd_rw         = 1'b0;

endmodule

// File: tb/tb_lcd_word_display.sv
// Bench for lcd_word_display: E-strobe monitor plus a string-formatting reference model.
module tb_lcd_word_display;

    localparam int S   = 1;
    localparam int E   = 2;
    localparam int H   = 1;
    localparam int CW  = 4;
    localparam int CLW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, rst1;
    logic busy, done, lcd_rs, lcd_rw, lcd_en;
    logic busy1, done1, lcd_rs1, lcd_rw1, lcd_en1;
    logic [7:0] lcd_data, lcd_data1;

    lcd_word_display_if #(.DATA_W(10)) bus ();
    lcd_word_display_if #(.DATA_W(1))  bus1 ();

    lcd_word_display #(
        .DATA_W(10), .SETUP_CYC(S), .EN_CYC(E), .HOLD_CYC(H), .CMD_WAIT(CW), .CLR_WAIT(CLW)
    ) u_dut (
        .clk(clk), .rst(rst), .in_if(bus), .busy(busy), .done(done),
        .lcd_data(lcd_data), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en)
    );

    lcd_word_display #(
        .DATA_W(1), .SETUP_CYC(S), .EN_CYC(E), .HOLD_CYC(H), .CMD_WAIT(CW), .CLR_WAIT(CLW)
    ) u_dut1 (
        .clk(clk), .rst(rst1), .in_if(bus1), .busy(busy1), .done(done1),
        .lcd_data(lcd_data1), .lcd_rs(lcd_rs1), .lcd_rw(lcd_rw1), .lcd_en(lcd_en1)
    );

    int checks = 0;
    int failures = 0;

    // Monitor: one entry {rs,data} per E rising edge, plus pulse widths and rise cycles.
    logic [8:0] mon_q[$];
    logic [8:0] mon1_q[$];
    logic [8:0] exp_q[$];
    int width_q[$];
    int rise_q[$];
    int cyc = 0;
    int cur_w = 0;
    int done_cnt = 0;
    int done1_cnt = 0;
    logic en_prev = 1'b0;
    logic en1_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (lcd_en === 1'b1) begin
            if (en_prev !== 1'b1) begin
                mon_q.push_back({lcd_rs, lcd_data});
                rise_q.push_back(cyc);
                cur_w = 0;
            end
            cur_w++;
        end else if (en_prev === 1'b1) begin
            width_q.push_back(cur_w);
        end
        if (done === 1'b1) done_cnt++;
        en_prev = lcd_en;
        if (lcd_en1 === 1'b1 && en1_prev !== 1'b1) mon1_q.push_back({lcd_rs1, lcd_data1});
        if (done1 === 1'b1) done1_cnt++;
        en1_prev = lcd_en1;
    end

    task automatic clear_mon();
        mon_q.delete();
        mon1_q.delete();
        width_q.delete();
        rise_q.delete();
        done_cnt  = 0;
        done1_cnt = 0;
    endtask

    // Reference: address command, then the word printed by $sformatf.
    task automatic build_exp(input logic [9:0] w, input bit hex, input int width);
        string s;
        logic [0:0] w1;
        exp_q.delete();
        exp_q.push_back({1'b0, 8'h80});
        if (width == 1) begin
            w1 = w[0];
            s  = hex ? $sformatf("%h", w1) : $sformatf("%b", w1);
        end else begin
            s = hex ? $sformatf("%h", w) : $sformatf("%b", w);
        end
        s = s.toupper();
        for (int i = 0; i < s.len(); i++) exp_q.push_back({1'b1, s[i]});
    endtask

    task automatic build_init_exp();
        exp_q.delete();
        exp_q.push_back(9'h038);
        exp_q.push_back(9'h00F);
        exp_q.push_back(9'h006);
        exp_q.push_back(9'h001);
    endtask

    function automatic bit q_match(input logic [8:0] got[$]);
        if (got.size() != exp_q.size()) return 1'b0;
        for (int i = 0; i < got.size(); i++) if (got[i] !== exp_q[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic string q_str(input logic [8:0] q[$]);
        string s = "";
        for (int i = 0; i < q.size(); i++) s = {s, $sformatf(" %03h", q[i])};
        return s;
    endfunction

    task automatic wait_ready(input bit which, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if ((which ? bus1.in_ready : bus.in_ready) === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic send(input bit which, input logic [9:0] w, input bit hex);
        @(negedge clk);
        if (which) begin
            bus1.in_data = w[0]; bus1.in_hex = hex; bus1.in_valid = 1'b1;
        end else begin
            bus.in_data = w; bus.in_hex = hex; bus.in_valid = 1'b1;
        end
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus1.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; rst1 = 1'b1;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.in_hex = 1'b0;
        bus1.in_valid = 1'b0; bus1.in_data = '0; bus1.in_hex = 1'b0;
        repeat (3) @(negedge clk);
        checks += 7;
        if (lcd_data !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", lcd_data); end
        if (lcd_rs !== 1'b0) begin failures++; $display("FAIL reset_rs got=%b exp=0", lcd_rs); end
        if (lcd_rw !== 1'b0) begin failures++; $display("FAIL reset_rw got=%b exp=0", lcd_rw); end
        if (lcd_en !== 1'b0) begin failures++; $display("FAIL reset_en got=%b exp=0", lcd_en); end
        if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", bus.in_ready); end
        if (busy !== 1'b1) begin failures++; $display("FAIL reset_busy got=%b exp=1", busy); end
        if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    endtask

    task automatic test_init();
        int since_fall = 0;
        bit ok = 1'b0;
        clear_mon();
        rst = 1'b0; rst1 = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (lcd_en === 1'b1) since_fall = 0; else since_fall++;
            if (bus.in_ready === 1'b1) begin ok = 1'b1; break; end
        end
        build_init_exp();
        checks += 5;
        if (!ok) begin failures++; $display("FAIL init_timeout got=ready_low exp=ready_high"); end
        if (!q_match(mon_q)) begin failures++; $display("FAIL init_bytes got=%s exp=%s", q_str(mon_q), q_str(exp_q)); end
        if (since_fall != H + CLW + 1) begin
            failures++; $display("FAIL init_ready_delay got=%0d exp=%0d", since_fall, H + CLW + 1);
        end
        if (width_q.size() != 4 || width_q[0] != E || width_q[1] != E || width_q[2] != E || width_q[3] != E) begin
            failures++; $display("FAIL init_en_width got=%p exp=all %0d", width_q, E);
        end
        if (rise_q.size() != 4 || rise_q[1] - rise_q[0] != S + E + H + CW
            || rise_q[2] - rise_q[1] != S + E + H + CW || rise_q[3] - rise_q[2] != S + E + H + CW) begin
            failures++; $display("FAIL init_byte_period got=%p exp=step %0d", rise_q, S + E + H + CW);
        end
    endtask

    task automatic test_binary();
        bit ok;
        bit per_ok = 1'b1;
        clear_mon();
        build_exp(10'b1010000011, 1'b0, 10);
        send(1'b0, 10'b1010000011, 1'b0);
        wait_ready(1'b0, 500, ok);
        for (int i = 1; i < rise_q.size(); i++) if (rise_q[i] - rise_q[i-1] != S + E + H + CW) per_ok = 1'b0;
        checks += 4;
        if (!ok) begin failures++; $display("FAIL bin_timeout got=busy exp=ready"); end
        if (!q_match(mon_q)) begin failures++; $display("FAIL bin_bytes got=%s exp=%s", q_str(mon_q), q_str(exp_q)); end
        if (done_cnt != 1) begin failures++; $display("FAIL bin_done got=%0d exp=1", done_cnt); end
        if (!per_ok) begin failures++; $display("FAIL bin_byte_period got=%p exp=step %0d", rise_q, S + E + H + CW); end
    endtask

    task automatic test_hex();
        bit ok;
        clear_mon();
        build_exp(10'h2A5, 1'b1, 10);
        send(1'b0, 10'h2A5, 1'b1);
        wait_ready(1'b0, 500, ok);
        checks += 4;
        if (!ok) begin failures++; $display("FAIL hex_timeout got=busy exp=ready"); end
        if (!q_match(mon_q)) begin failures++; $display("FAIL hex_bytes got=%s exp=%s", q_str(mon_q), q_str(exp_q)); end
        if (mon_q.size() != 4) begin failures++; $display("FAIL hex_count got=%0d exp=4", mon_q.size()); end
        if (done_cnt != 1) begin failures++; $display("FAIL hex_done got=%0d exp=1", done_cnt); end
    endtask

    task automatic test_busy_ignore();
        bit ok;
        logic [9:0] w = 10'($urandom);
        bit hex = 1'b1;
        clear_mon();
        build_exp(w, hex, 10);
        send(1'b0, w, hex);
        repeat (6) @(negedge clk);
        bus.in_data = ~w; bus.in_hex = 1'b0; bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (5) @(negedge clk);
        bus.in_data = 10'($urandom); bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        wait_ready(1'b0, 500, ok);
        repeat (40) @(negedge clk);
        checks += 4;
        if (!ok) begin failures++; $display("FAIL busy_timeout got=busy exp=ready"); end
        if (!q_match(mon_q)) begin failures++; $display("FAIL busy_bytes got=%s exp=%s", q_str(mon_q), q_str(exp_q)); end
        if (done_cnt != 1) begin failures++; $display("FAIL busy_done got=%0d exp=1", done_cnt); end
        if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL busy_idle got=%b exp=1", bus.in_ready); end
    endtask

    task automatic test_reset_mid();
        bit ok = 1'b0;
        clear_mon();
        send(1'b0, 10'b1010000011, 1'b0);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            #1;
            if (mon_q.size() >= 5) begin ok = 1'b1; break; end
        end
        checks += 2;
        if (!ok) begin failures++; $display("FAIL rstmid_reach got=%0d exp=5", mon_q.size()); end
        if (lcd_en !== 1'b1) begin failures++; $display("FAIL rstmid_en_pre got=%b exp=1", lcd_en); end
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (lcd_en !== 1'b0) begin failures++; $display("FAIL rstmid_en_drop got=%b exp=0", lcd_en); end
        rst = 1'b0;
        clear_mon();
        wait_ready(1'b0, 300, ok);
        build_init_exp();
        checks += 3;
        if (!ok) begin failures++; $display("FAIL rstmid_timeout got=busy exp=ready"); end
        if (!q_match(mon_q)) begin failures++; $display("FAIL rstmid_bytes got=%s exp=%s", q_str(mon_q), q_str(exp_q)); end
        if (done_cnt != 0) begin failures++; $display("FAIL rstmid_done got=%0d exp=0", done_cnt); end
    endtask

    task automatic test_random();
        bit ok;
        logic [9:0] w;
        bit hex;
        for (int n = 0; n < 8; n++) begin
            w   = 10'($urandom);
            hex = 1'($urandom);
            clear_mon();
            build_exp(w, hex, 10);
            send(1'b0, w, hex);
            wait_ready(1'b0, 500, ok);
            checks += 2;
            if (!ok || done_cnt != 1) begin
                failures++; $display("FAIL rand_done w=%h hex=%b got=%0d exp=1", w, hex, done_cnt);
            end
            if (!q_match(mon_q)) begin
                failures++; $display("FAIL rand_bytes w=%h hex=%b got=%s exp=%s", w, hex, q_str(mon_q), q_str(exp_q));
            end
        end
    endtask

    task automatic test_width1();
        bit ok;
        logic [9:0] words [3] = '{10'd1, 10'd1, 10'd0};
        bit modes [3] = '{1'b0, 1'b1, 1'b1};
        wait_ready(1'b1, 300, ok);
        for (int n = 0; n < 3; n++) begin
            clear_mon();
            build_exp(words[n], modes[n], 1);
            send(1'b1, words[n], modes[n]);
            wait_ready(1'b1, 300, ok);
            checks += 2;
            if (!ok || done1_cnt != 1) begin
                failures++; $display("FAIL w1_done case=%0d got=%0d exp=1", n, done1_cnt);
            end
            if (!q_match(mon1_q)) begin
                failures++; $display("FAIL w1_bytes case=%0d got=%s exp=%s", n, q_str(mon1_q), q_str(exp_q));
            end
        end
    endtask

    initial begin
        test_reset();
        test_init();
        test_binary();
        test_hex();
        test_busy_ignore();
        test_reset_mid();
        test_random();
        test_width1();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
